// File: rtl/seq_multiplier_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// master issues operands and consumes the product; slave is the multiplier.
interface seq_multiplier_if #(
    parameter int BUS = 4
);
    logic           start;
    logic           signed_mode;
    logic [BUS-1:0] a;
    logic [BUS-1:0] b;
    logic           ready;
    logic           done;
    logic [BUS-1:0] result;
    logic [BUS-1:0] result_hi;
    logic           overflow;
    logic           zero;
    logic           negative;
    logic           carry_out;

    modport master (
        output start, signed_mode, a, b,
        input  ready, done, result, result_hi, overflow, zero, negative, carry_out
    );

    modport slave (
        input  start, signed_mode, a, b,
        output ready, done, result, result_hi, overflow, zero, negative, carry_out
    );
endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier (unsigned / two's-complement), full 2*BUS-bit product.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: leave CALC once the remaining multiplier is zero.
module seq_multiplier #(
    parameter int BUS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_multiplier_if.slave mul
);
    localparam int PW = 2 * BUS;
    localparam int CW = $clog2(BUS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_signed;
    logic            r_sign;
    logic [PW-1:0]   r_mcand;
    logic [BUS-1:0]  r_mult;
    logic [PW-1:0]   r_acc;
    logic [BUS-1:0]  r_result;
    logic [BUS-1:0]  r_result_hi;
    logic            r_overflow;
    logic            r_zero;
    logic            r_negative;
    logic            r_carry;

    logic [BUS-1:0]  w_mult_nxt;
    logic            w_last;
    logic            w_accept;
    logic [PW-1:0]   w_prod;
    logic [BUS-1:0]  w_prod_lo;
    logic [BUS-1:0]  w_prod_hi;

    // |-2^(BUS-1)| wraps to 2^(BUS-1), which is still correct read as unsigned.
    function automatic logic [BUS-1:0] f_mag(input logic [BUS-1:0] x, input logic sgn_mode);
        return (sgn_mode && x[BUS-1]) ? (~x + BUS'(1)) : x;
    endfunction

    function automatic logic [PW-1:0] f_apply_sign(input logic [PW-1:0] acc, input logic neg);
        return neg ? (~acc + PW'(1)) : acc;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && mul.start;
    assign w_mult_nxt = r_mult >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign w_last     = (r_cnt == CW'(1)) || (w_mult_nxt == '0);
`else
    assign w_last     = (r_cnt == CW'(1));
`endif

    assign w_prod     = f_apply_sign(r_acc, r_sign);
    assign w_prod_lo  = w_prod[BUS-1:0];
    assign w_prod_hi  = w_prod[PW-1:BUS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_cnt <= CW'(BUS);
            else if (r_state == S_CALC)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (mul.start) w_state_nxt = S_CALC;
            S_CALC: if (w_last)    w_state_nxt = S_FIX;
            S_FIX:                 w_state_nxt = S_DONE;
            S_DONE:                w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Operand/accumulator datapath carries no reset; the FSM alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_signed <= mul.signed_mode;
            r_sign   <= mul.signed_mode & (mul.a[BUS-1] ^ mul.b[BUS-1]);
            r_mcand  <= {{BUS{1'b0}}, f_mag(mul.a, mul.signed_mode)};
            r_mult   <= f_mag(mul.b, mul.signed_mode);
            r_acc    <= '0;
        end else if (r_state == S_CALC) begin
            if (r_mult[0])
                r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_mult  <= w_mult_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_result    <= w_prod_lo;
            r_result_hi <= w_prod_hi;
            r_zero      <= (w_prod == '0);
            r_negative  <= w_prod_lo[BUS-1];
            r_carry     <= w_prod[BUS];
            r_overflow  <= r_signed ? (w_prod_hi != {BUS{w_prod_lo[BUS-1]}})
                                    : (w_prod_hi != '0);
        end
    end

    assign mul.ready     = (r_state == S_IDLE);
    assign mul.done      = (r_state == S_DONE);
    assign mul.result    = r_result;
    assign mul.result_hi = r_result_hi;
    assign mul.overflow  = r_overflow;
    assign mul.zero      = r_zero;
    assign mul.negative  = r_negative;
    assign mul.carry_out = r_carry;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at BUS=4; flags compared as {overflow,zero,negative,carry_out}.
module tb_seq_multiplier;
    localparam int BUS = 4;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   saved_done;

    seq_multiplier_if #(.BUS(BUS)) mi ();

    seq_multiplier #(.BUS(BUS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mul   (mi.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mi.done) n_done++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] flags();
        return {mi.overflow, mi.zero, mi.negative, mi.carry_out};
    endfunction

    // Called #1 after a clock edge; returns with the bench #1 after the done edge.
    task automatic run(input string tag, input logic sm, input logic [3:0] a, input logic [3:0] b,
                       input int lat_ee, input logic [3:0] e_lo, input logic [3:0] e_hi,
                       input logic [3:0] e_flags);
        int lat;
        int exp_lat;
        exp_lat = EE ? lat_ee : BUS + 1;
        mi.start       = 1'b1;
        mi.signed_mode = sm;
        mi.a           = a;
        mi.b           = b;
        @(posedge clk);
        #1;
        mi.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mi.done) break;
        end
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".done"}, mi.done, 1'b1);
        chk({tag, ".ready_in_done"}, mi.ready, 1'b0);
        chk({tag, ".result"}, mi.result, e_lo);
        chk({tag, ".result_hi"}, mi.result_hi, e_hi);
        chk({tag, ".flags"}, flags(), e_flags);
        @(posedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, mi.done, 1'b0);
        chk({tag, ".ready_back"}, mi.ready, 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        mi.start       = 1'b0;
        mi.signed_mode = 1'b0;
        mi.a           = '0;
        mi.b           = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", mi.ready, 1'b1);
        chk("rst.done", mi.done, 1'b0);
        chk("rst.result", mi.result, 4'h0);
        chk("rst.result_hi", mi.result_hi, 4'h0);
        chk("rst.flags", flags(), 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 7x7 aborted by reset on edge 2
        saved_done     = n_done;
        mi.start       = 1'b1;
        mi.signed_mode = 1'b0;
        mi.a           = 4'd7;
        mi.b           = 4'd7;
        @(posedge clk);
        #1;
        mi.start = 1'b0;
        chk("abort.busy", mi.ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.ready", mi.ready, 1'b1);
        chk("abort.done", mi.done, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.no_done", n_done, saved_done);
        chk("abort.result", mi.result, 4'h0);
        chk("abort.flags", flags(), 4'b0000);
        run("u2x3", 1'b0, 4'd2, 4'd3, 3, 4'h6, 4'h0, 4'b0000);

        run("u15x15", 1'b0, 4'hF, 4'hF, 5, 4'h1, 4'hE, 4'b1000);
        run("s-8x-8", 1'b1, 4'h8, 4'h8, 5, 4'h0, 4'h4, 4'b1000);
        run("s-2x3",  1'b1, 4'hE, 4'h3, 3, 4'hA, 4'hF, 4'b0011);
        run("u0x9",   1'b0, 4'h0, 4'h9, 5, 4'h0, 4'h0, 4'b0100);

        // 3x5 with a stray start and operand change mid-CALC
        saved_done     = n_done;
        mi.start       = 1'b1;
        mi.signed_mode = 1'b0;
        mi.a           = 4'd3;
        mi.b           = 4'd5;
        @(posedge clk);
        #1;
        mi.start = 1'b0;
        @(posedge clk);
        #1;
        mi.start       = 1'b1;
        mi.signed_mode = 1'b1;
        mi.a           = 4'hF;
        mi.b           = 4'h9;
        @(posedge clk);
        #1;
        mi.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("busy.one_done", n_done - saved_done, 1);
        chk("busy.result", mi.result, 4'hF);
        chk("busy.result_hi", mi.result_hi, 4'h0);
        chk("busy.flags", flags(), 4'b0010);
        chk("busy.ready", mi.ready, 1'b1);

        run("u3x1", 1'b0, 4'd3, 4'd1, 2, 4'h3, 4'h0, 4'b0000);
        run("u3x8", 1'b0, 4'd3, 4'd8, 5, 4'h8, 4'h1, 4'b1011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
